// File: rtl/line_buffer_fifo.sv
// line_buffer_fifo: single-clock FWFT/std FIFO for the scan-line pixel path, with reset-busy sequencing.
// In FWFT mode the head word lives in an output register; counts include it.
module line_buffer_fifo #(
  parameter int    FIFO_WRITE_DEPTH  = 512,
  parameter int    WRITE_DATA_WIDTH  = 128,
  parameter string READ_MODE         = "fwft",
  parameter int    PROG_FULL_THRESH  = 500,
  parameter int    PROG_EMPTY_THRESH = 10,
  parameter int    RST_BUSY_CYCLES   = 4,
  parameter int    CW                = $clog2(FIFO_WRITE_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WRITE_DATA_WIDTH-1:0] i_din,
  input  logic                        i_wr_en,
  output logic                        o_full,
  output logic                        o_almost_full,
  output logic                        o_prog_full,
  output logic [CW-1:0]               o_wr_data_count,
  output logic                        o_overflow,
  output logic                        o_wr_ack,
  output logic                        o_wr_rst_busy,
  input  logic                        i_rd_en,
  output logic [WRITE_DATA_WIDTH-1:0] o_dout,
  output logic                        o_empty,
  output logic                        o_almost_empty,
  output logic                        o_prog_empty,
  output logic [CW-1:0]               o_rd_data_count,
  output logic                        o_underflow,
  output logic                        o_data_valid,
  output logic                        o_rd_rst_busy
);
  localparam int AW = $clog2(FIFO_WRITE_DEPTH);
  localparam bit FWFT = (READ_MODE == "fwft");
  logic [WRITE_DATA_WIDTH-1:0] r_mem [FIFO_WRITE_DEPTH];
  logic [WRITE_DATA_WIDTH-1:0] r_dout;
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_bcnt;
  logic r_ov, r_busy, r_full, r_afull, r_pfull, r_empty, r_aempty, r_pempty;
  logic r_ovf, r_udf, r_ack, r_valid;
  logic w_wr, w_rd, w_load, w_ov_n, w_busy_n;
  logic [CW-1:0] w_mem_cnt, w_cnt_n;
  always_comb begin
    w_wr      = i_wr_en && !r_full && !r_busy;
    w_rd      = i_rd_en && !r_empty && !r_busy;
    w_mem_cnt = r_count - CW'(r_ov);
    // FWFT refills the head register whenever it is vacant or being popped
    w_load    = FWFT ? (w_mem_cnt != '0) && (!r_ov || w_rd) : w_rd;
    w_ov_n    = FWFT && (w_load || (r_ov && !w_rd));
    w_cnt_n   = r_count + CW'(w_wr) - CW'(w_rd);
    w_busy_n  = r_busy && (r_bcnt != 8'(RST_BUSY_CYCLES - 1));
  end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wptr] <= i_din;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_dout   <= '0;
      r_ov     <= 1'b0;
      r_busy   <= 1'b1;
      r_bcnt   <= '0;
      r_full   <= 1'b1;
      r_afull  <= 1'b0;
      r_pfull  <= 1'b1;
      r_empty  <= 1'b1;
      r_aempty <= 1'b0;
      r_pempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_ack    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_bcnt   <= r_busy ? r_bcnt + 8'd1 : r_bcnt;
      r_busy   <= w_busy_n;
      r_wptr   <= w_wr ? r_wptr + 1'b1 : r_wptr;
      r_rptr   <= w_load ? r_rptr + 1'b1 : r_rptr;
      r_dout   <= w_load ? r_mem[r_rptr] : r_dout;
      r_ov     <= w_ov_n;
      r_count  <= w_cnt_n;
      r_full   <= w_busy_n || (w_cnt_n == CW'(FIFO_WRITE_DEPTH));
      r_afull  <= w_cnt_n == CW'(FIFO_WRITE_DEPTH - 1);
      r_pfull  <= w_busy_n || (w_cnt_n >= CW'(PROG_FULL_THRESH));
      r_empty  <= FWFT ? !w_ov_n : (w_cnt_n == '0);
      r_aempty <= w_cnt_n == CW'(1);
      r_pempty <= w_cnt_n <= CW'(PROG_EMPTY_THRESH);
      r_ovf    <= i_wr_en && r_full && !r_busy;
      r_udf    <= i_rd_en && r_empty && !r_busy;
      r_ack    <= w_wr;
      r_valid  <= FWFT ? w_ov_n : w_rd;
    end
  end
  assign o_full          = r_full;
  assign o_almost_full   = r_afull;
  assign o_prog_full     = r_pfull;
  assign o_wr_data_count = r_count;
  assign o_overflow      = r_ovf;
  assign o_wr_ack        = r_ack;
  assign o_wr_rst_busy   = r_busy;
  assign o_dout          = r_dout;
  assign o_empty         = r_empty;
  assign o_almost_empty  = r_aempty;
  assign o_prog_empty    = r_pempty;
  assign o_rd_data_count = r_count;
  assign o_underflow     = r_udf;
  assign o_data_valid    = r_valid;
  assign o_rd_rst_busy   = r_busy;
endmodule

// File: tb/tb_line_buffer_fifo.sv
// tb_line_buffer_fifo: directed vector table plus hand sequences for reset, fill, wrap streaming and mid-stream reset.
module tb_line_buffer_fifo;
  logic clk = 1'b0, rst = 1'b0;
  logic [127:0] din = '0, dout;
  logic wr_en = 1'b0, rd_en = 1'b0;
  logic full, almost_full, prog_full, overflow, wr_ack, wr_rst_busy;
  logic empty, almost_empty, prog_empty, underflow, data_valid, rd_rst_busy;
  logic [9:0] wr_cnt, rd_cnt;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  line_buffer_fifo dut (
    .clk(clk), .rst(rst), .i_din(din), .i_wr_en(wr_en), .o_full(full), .o_almost_full(almost_full),
    .o_prog_full(prog_full), .o_wr_data_count(wr_cnt), .o_overflow(overflow), .o_wr_ack(wr_ack),
    .o_wr_rst_busy(wr_rst_busy), .i_rd_en(rd_en), .o_dout(dout), .o_empty(empty),
    .o_almost_empty(almost_empty), .o_prog_empty(prog_empty), .o_rd_data_count(rd_cnt),
    .o_underflow(underflow), .o_data_valid(data_valid), .o_rd_rst_busy(rd_rst_busy)
  );
  typedef struct {
    logic wr, rd;
    logic [127:0] din, dout;
    logic chk_dout, empty, valid, ack, ovf, udf, ae;
    logic [9:0] cnt;
  } vec_t;
  vec_t vecs [10];
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t mk(input logic wr, rd, input logic [127:0] d, dx, input logic cd, e, dv, ack, ovf, udf, ae,
                              input logic [9:0] cnt);
    mk = '{wr, rd, d, dx, cd, e, dv, ack, ovf, udf, ae, cnt};
  endfunction
  initial begin
    vecs[0] = mk(1'b1, 1'b0, 128'hA5, 128'h0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'd1);
    vecs[1] = mk(1'b0, 1'b0, 128'h0,  128'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd1);
    vecs[2] = mk(1'b0, 1'b1, 128'h0,  128'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
    vecs[3] = mk(1'b1, 1'b1, 128'h7,  128'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 10'd1);
    vecs[4] = mk(1'b0, 1'b0, 128'h0,  128'h7,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd1);
    vecs[5] = mk(1'b1, 1'b0, 128'h11, 128'h7,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd2);
    vecs[6] = mk(1'b1, 1'b1, 128'h22, 128'h11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd2);
    vecs[7] = mk(1'b0, 1'b1, 128'h0,  128'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd1);
    vecs[8] = mk(1'b0, 1'b1, 128'h0,  128'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
    vecs[9] = mk(1'b0, 1'b1, 128'h0,  128'h22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
    // reset sequencing
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", 128'({wr_rst_busy, rd_rst_busy}), 128'h3);
    chk("rst_flags", 128'({full, prog_full, empty, prog_empty, almost_full, almost_empty}), 128'b111100);
    chk("rst_cnt", 128'({wr_cnt, rd_cnt}), 128'h0);
    chk("rst_dout", dout, 128'h0);
    repeat (3) step();
    rst = 1'b0;
    wr_en = 1'b1;
    din = 128'hDEAD;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("busy_e%0d", i), 128'({wr_rst_busy, rd_rst_busy, full, prog_full}), (i < 4) ? 128'hF : 128'h0);
      chk($sformatf("busy_ign_e%0d", i), 128'({wr_ack, overflow, underflow}), 128'h0);
    end
    wr_en = 1'b0;
    step();
    chk("post_busy_cnt", 128'({wr_cnt, rd_cnt}), 128'h0);
    chk("post_busy_flags", 128'({empty, full, wr_ack}), 128'b100);
    // vector table: FWFT latency, underflow with simultaneous write, no-bubble pop
    foreach (vecs[i]) begin
      wr_en = vecs[i].wr;
      rd_en = vecs[i].rd;
      din = vecs[i].din;
      step();
      if (vecs[i].chk_dout) chk($sformatf("v%0d_dout", i), dout, vecs[i].dout);
      chk($sformatf("v%0d_empty", i), 128'(empty), 128'(vecs[i].empty));
      chk($sformatf("v%0d_valid", i), 128'(data_valid), 128'(vecs[i].valid));
      chk($sformatf("v%0d_ack", i), 128'(wr_ack), 128'(vecs[i].ack));
      chk($sformatf("v%0d_ovf", i), 128'(overflow), 128'(vecs[i].ovf));
      chk($sformatf("v%0d_udf", i), 128'(underflow), 128'(vecs[i].udf));
      chk($sformatf("v%0d_ae", i), 128'(almost_empty), 128'(vecs[i].ae));
      chk($sformatf("v%0d_cnt", i), 128'({wr_cnt, rd_cnt}), 128'({vecs[i].cnt, vecs[i].cnt}));
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    // fill to full, overflow, then drain in order
    for (int i = 0; i < 512; i++) begin
      wr_en = 1'b1;
      din = 128'(i);
      step();
      chk($sformatf("fill%0d_cnt", i), 128'(wr_cnt), 128'(i + 1));
      chk($sformatf("fill%0d_flags", i), 128'({almost_full, full, prog_full}),
          128'({i + 1 == 511, i + 1 == 512, i + 1 >= 500}));
    end
    din = 128'h1FF_FFFF;
    step();
    chk("ovf_pulse", 128'({overflow, wr_ack, full}), 128'b101);
    chk("ovf_cnt", 128'(rd_cnt), 128'd512);
    wr_en = 1'b0;
    step();
    chk("ovf_clear", 128'(overflow), 128'h0);
    for (int i = 0; i < 512; i++) begin
      chk($sformatf("drain%0d", i), dout, 128'(i));
      chk($sformatf("drain%0d_empty", i), 128'(empty), 128'h0);
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
    chk("drain_end", 128'({empty, wr_cnt, underflow}), 128'({1'b1, 10'd0, 1'b0}));
    // streaming across pointer wrap with two words in flight
    wr_en = 1'b1;
    din = {96'hC0FFEE, 32'd0};
    step();
    din = {96'hC0FFEE, 32'd1};
    step();
    wr_en = 1'b0;
    step();
    for (int j = 0; j < 2000; j++) begin
      chk($sformatf("strm%0d", j), dout, {96'hC0FFEE, 32'(j)});
      wr_en = 1'b1;
      rd_en = 1'b1;
      din = {96'hC0FFEE, 32'(j + 2)};
      step();
      chk($sformatf("strm%0d_cnt", j), 128'(rd_cnt), 128'd2);
      chk($sformatf("strm%0d_err", j), 128'({overflow, underflow, empty}), 128'h0);
    end
    wr_en = 1'b0;
    repeat (2) step();
    rd_en = 1'b0;
    chk("strm_drained", 128'({empty, rd_cnt}), 128'({1'b1, 10'd0}));
    // mid-stream reset
    for (int i = 0; i < 100; i++) begin
      wr_en = 1'b1;
      din = 128'(1000 + i);
      step();
    end
    wr_en = 1'b0;
    chk("mid_cnt", 128'(wr_cnt), 128'd100);
    rst = 1'b1;
    #1;
    chk("mid_rst_now", 128'({wr_rst_busy, full, empty, wr_cnt}), 128'({3'b111, 10'd0}));
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("mid_busy3", 128'({rd_rst_busy, full}), 128'b11);
    step();
    chk("mid_busy_clear", 128'({rd_rst_busy, full, empty, rd_cnt}), 128'({3'b001, 10'd0}));
    wr_en = 1'b1;
    din = 128'h55AA;
    step();
    wr_en = 1'b0;
    step();
    chk("mid_first_word", dout, 128'h55AA);
    chk("mid_first_cnt", 128'({empty, data_valid, rd_cnt}), 128'({2'b01, 10'd1}));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
